// File: rtl/uoram_stream_datapath.sv
// Frontend data path for the unified ORAM: steers chunks between the network, the PLB
// evict/refill ports and the backend store/load channels under a per-block transfer FSM.
module uoram_stream_datapath #(
    parameter int FEDWidth    = 64,
    parameter int LeafWidth   = 32,
    parameter int BlockChunks = 8,
    parameter int EvictDepth  = BlockChunks * (FEDWidth / LeafWidth),
    parameter int BECMDWidth  = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  SwitchReq,
    input  logic                  DataBlockReq,
    input  logic                  DummyReq,
    input  logic [BECMDWidth-1:0] Cmd,
    output logic                  Busy,
    output logic                  ExpectingProgramData,
    output logic                  DataInReady,
    input  logic                  DataInValid,
    input  logic [FEDWidth-1:0]   DataIn,
    input  logic                  ReturnDataReady,
    output logic                  ReturnDataValid,
    output logic [FEDWidth-1:0]   ReturnData,
    output logic                  PPPEvictDataReady,
    input  logic                  PPPEvictDataValid,
    input  logic [LeafWidth-1:0]  PPPEvictData,
    input  logic                  PPPRefillDataReady,
    output logic                  PPPRefillDataValid,
    output logic [LeafWidth-1:0]  PPPRefillData,
    input  logic                  StoreDataReady,
    output logic                  StoreDataValid,
    output logic [FEDWidth-1:0]   StoreData,
    output logic                  LoadDataReady,
    input  logic                  LoadDataValid,
    input  logic [FEDWidth-1:0]   LoadData,
    output logic                  ErrUnexpectedLoad,
    output logic                  ErrSwitchBusy
);
    localparam int R   = FEDWidth / LeafWidth;
    localparam int CW  = $clog2(BlockChunks) + 1;
    localparam int FAW = (EvictDepth > 1) ? $clog2(EvictDepth) : 1;
    localparam int FCW = $clog2(EvictDepth + 1);
    localparam int PCW = $clog2(R + 1);
    localparam logic [CW-1:0]  CHUNKS = CW'(BlockChunks);
    localparam logic [PCW-1:0] LEAVES = PCW'(R);

    typedef enum logic [2:0] {IDLE, PROG_LOAD, PROG_STORE, FAKE, POSMAP} state_t;

    state_t state, state_next;
    logic [CW-1:0] store_cnt, load_cnt, store_cnt_next, load_cnt_next;
    logic [CW-1:0] store_req, load_req;
    logic store_open, load_open, store_fire, load_fire, done, cmd_read;

    logic                 in_valid;
    logic [LeafWidth-1:0] in_data;
    logic [LeafWidth-1:0] mem [EvictDepth];
    logic [FAW-1:0]       wr_ptr, rd_ptr;
    logic [FCW-1:0]       fifo_count;
    logic fifo_full, fifo_push, fifo_pop, evict_fire;

    logic [FEDWidth-1:0] pack_data, unpack_data;
    logic [PCW-1:0]      pack_cnt, pack_base, unpack_cnt;
    logic pack_full, pack_store, posmap_load, refill_fire;

    function automatic logic [FAW-1:0] ptr_inc(input logic [FAW-1:0] p);
        return (p == FAW'(EvictDepth - 1)) ? '0 : p + FAW'(1);
    endfunction

    assign cmd_read             = (Cmd == BECMDWidth'(2)) || (Cmd == BECMDWidth'(3));
    assign Busy                 = (state != IDLE);
    assign ExpectingProgramData = (state == PROG_LOAD) || (state == PROG_STORE) || (state == FAKE);

    always_comb begin
        store_req = '0;
        load_req  = '0;
        case (state)
            PROG_LOAD:    load_req = CHUNKS;
            PROG_STORE:   store_req = CHUNKS;
            FAKE, POSMAP: begin
                store_req = CHUNKS;
                load_req  = CHUNKS;
            end
            default: ;
        endcase
    end

    assign store_open = (store_cnt < store_req);
    assign load_open  = (load_cnt < load_req);

    // Per-mode steering of the store and load channels.
    always_comb begin
        DataInReady     = 1'b0;
        StoreDataValid  = 1'b0;
        StoreData       = '0;
        ReturnDataValid = 1'b0;
        ReturnData      = '0;
        LoadDataReady   = 1'b0;
        case (state)
            PROG_LOAD: begin
                LoadDataReady   = ReturnDataReady && load_open;
                ReturnDataValid = LoadDataValid && load_open;
                ReturnData      = LoadData;
            end
            PROG_STORE: begin
                DataInReady    = StoreDataReady && store_open;
                StoreDataValid = DataInValid && store_open;
                StoreData      = DataIn;
            end
            FAKE: begin
                StoreDataValid  = store_open;
                StoreData       = FEDWidth'(store_cnt);
                ReturnDataValid = load_open;
                ReturnData      = FEDWidth'(load_cnt);
            end
            POSMAP: begin
                StoreDataValid = pack_full && store_open;
                StoreData      = pack_data;
                LoadDataReady  = (unpack_cnt == '0) && load_open;
            end
            default: ;
        endcase
    end

    assign store_fire     = StoreDataValid && StoreDataReady;
    assign load_fire      = (state == FAKE) ? (ReturnDataValid && ReturnDataReady)
                                            : (LoadDataValid && LoadDataReady);
    assign store_cnt_next = store_cnt + CW'(store_fire);
    assign load_cnt_next  = load_cnt + CW'(load_fire);
    assign done           = (state != IDLE) && (store_cnt_next == store_req)
                            && (load_cnt_next == load_req);

    always_comb begin
        state_next = state;
        if (state == IDLE) begin
            if (SwitchReq) begin
                if (!DataBlockReq)  state_next = POSMAP;
                else if (!cmd_read) state_next = PROG_STORE;
                else if (DummyReq)  state_next = FAKE;
                else                state_next = PROG_LOAD;
            end
        end else if (done) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state             <= IDLE;
            store_cnt         <= '0;
            load_cnt          <= '0;
            ErrUnexpectedLoad <= 1'b0;
            ErrSwitchBusy     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE || done) begin
                store_cnt <= '0;
                load_cnt  <= '0;
            end else begin
                store_cnt <= store_cnt_next;
                load_cnt  <= load_cnt_next;
            end
            if (LoadDataValid && (state == IDLE || state == PROG_STORE || state == FAKE))
                ErrUnexpectedLoad <= 1'b1;
            if (SwitchReq && Busy)
                ErrSwitchBusy <= 1'b1;
        end
    end

    // Evict path: one-leaf input register feeding the leaf FIFO; the packer only drains in POSMAP.
    assign fifo_full         = (fifo_count == FCW'(EvictDepth));
    assign PPPEvictDataReady = !in_valid || !fifo_full;
    assign evict_fire        = PPPEvictDataValid && PPPEvictDataReady;
    assign fifo_push         = in_valid && !fifo_full;
    assign pack_full         = (pack_cnt == LEAVES);
    assign pack_store        = (state == POSMAP) && store_fire;
    assign fifo_pop          = (state == POSMAP) && (fifo_count != '0) && (!pack_full || pack_store);
    assign pack_base         = pack_store ? '0 : pack_cnt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            in_valid   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            pack_cnt   <= '0;
        end else begin
            if (evict_fire)     in_valid <= 1'b1;
            else if (fifo_push) in_valid <= 1'b0;
            if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + FCW'(fifo_push) - FCW'(fifo_pop);
            if (fifo_pop)        pack_cnt <= pack_base + PCW'(1);
            else if (pack_store) pack_cnt <= '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (evict_fire) in_data <= PPPEvictData;
        if (fifo_push)  mem[wr_ptr] <= in_data;
        if (fifo_pop)   pack_data[int'(pack_base) * LeafWidth +: LeafWidth] <= mem[rd_ptr];
    end

    // Refill path: a loaded chunk is shifted out low leaf first.
    assign posmap_load        = (state == POSMAP) && load_fire;
    assign PPPRefillDataValid = (unpack_cnt != '0);
    assign PPPRefillData      = unpack_data[LeafWidth-1:0];
    assign refill_fire        = PPPRefillDataValid && PPPRefillDataReady;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            unpack_cnt  <= '0;
            unpack_data <= '0;
        end else if (posmap_load) begin
            unpack_cnt  <= LEAVES;
            unpack_data <= LoadData;
        end else if (refill_fire) begin
            unpack_cnt  <= unpack_cnt - PCW'(1);
            unpack_data <= unpack_data >> LeafWidth;
        end
    end
endmodule

// File: tb/tb_uoram_stream_datapath.sv
// Self-checking bench: queue-based scoreboard of every handshake plus directed scenarios.
module tb_uoram_stream_datapath;
    localparam int FW = 64;
    localparam int LW = 32;
    localparam int R  = FW / LW;
    localparam int M_IDLE = 0, M_POSMAP = 1, M_FAKE = 2, M_STORE = 3, M_LOAD = 4;

    logic Clock = 1'b0, Reset = 1'b0;
    logic SwitchReq = 0, DataBlockReq = 0, DummyReq = 0;
    logic [1:0] Cmd = '0;
    logic Busy, ExpectingProgramData;
    logic DataInReady, DataInValid = 0;
    logic [FW-1:0] DataIn = '0;
    logic ReturnDataReady = 0, ReturnDataValid;
    logic [FW-1:0] ReturnData;
    logic PPPEvictDataReady, PPPEvictDataValid = 0;
    logic [LW-1:0] PPPEvictData = '0;
    logic PPPRefillDataReady = 0, PPPRefillDataValid;
    logic [LW-1:0] PPPRefillData;
    logic StoreDataReady = 0, StoreDataValid;
    logic [FW-1:0] StoreData;
    logic LoadDataReady, LoadDataValid = 0;
    logic [FW-1:0] LoadData = '0;
    logic ErrUnexpectedLoad, ErrSwitchBusy;

    uoram_stream_datapath dut (
        .Clock(Clock), .Reset(Reset), .SwitchReq(SwitchReq), .DataBlockReq(DataBlockReq),
        .DummyReq(DummyReq), .Cmd(Cmd), .Busy(Busy), .ExpectingProgramData(ExpectingProgramData),
        .DataInReady(DataInReady), .DataInValid(DataInValid), .DataIn(DataIn),
        .ReturnDataReady(ReturnDataReady), .ReturnDataValid(ReturnDataValid), .ReturnData(ReturnData),
        .PPPEvictDataReady(PPPEvictDataReady), .PPPEvictDataValid(PPPEvictDataValid),
        .PPPEvictData(PPPEvictData), .PPPRefillDataReady(PPPRefillDataReady),
        .PPPRefillDataValid(PPPRefillDataValid), .PPPRefillData(PPPRefillData),
        .StoreDataReady(StoreDataReady), .StoreDataValid(StoreDataValid), .StoreData(StoreData),
        .LoadDataReady(LoadDataReady), .LoadDataValid(LoadDataValid), .LoadData(LoadData),
        .ErrUnexpectedLoad(ErrUnexpectedLoad), .ErrSwitchBusy(ErrSwitchBusy)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;
    int mode_m = M_IDLE;
    int store_n = 0;
    int ret_n = 0;
    logic [LW-1:0] evict_q[$];
    logic [LW-1:0] refill_q[$];
    logic [FW-1:0] datain_q[$];
    logic [FW-1:0] loadret_q[$];
    logic [FW-1:0] store_log[$];
    logic [FW-1:0] ret_log[$];
    logic [LW-1:0] refill_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=timeout required=handshake", name);
    endtask

    // Scoreboard: transfers are observed at the negedge before the edge that commits them.
    always @(negedge Clock) begin : monitor
        logic [FW-1:0] exp;
        if (Reset) begin
            if (PPPEvictDataValid && PPPEvictDataReady) evict_q.push_back(PPPEvictData);
            if (DataInValid && DataInReady) datain_q.push_back(DataIn);
            if (LoadDataValid && LoadDataReady) begin
                if (mode_m == M_POSMAP)
                    for (int r = 0; r < R; r++) refill_q.push_back(LoadData[r*LW +: LW]);
                else
                    loadret_q.push_back(LoadData);
            end
            if (StoreDataValid && StoreDataReady) begin
                exp = '0;
                if (mode_m == M_POSMAP) begin
                    if (evict_q.size() < R) timeout_fail("store_posmap_underrun");
                    for (int r = 0; r < R; r++)
                        if (evict_q.size() > 0) exp[r*LW +: LW] = evict_q.pop_front();
                end else if (mode_m == M_FAKE) begin
                    exp = FW'(store_n);
                end else if (datain_q.size() > 0) begin
                    exp = datain_q.pop_front();
                end else begin
                    exp = ~StoreData;
                end
                check("store_data", StoreData, exp);
                store_log.push_back(StoreData);
                store_n++;
            end
            if (ReturnDataValid && ReturnDataReady) begin
                if (mode_m == M_FAKE) exp = FW'(ret_n);
                else if (loadret_q.size() > 0) exp = loadret_q.pop_front();
                else exp = ~ReturnData;
                check("return_data", ReturnData, exp);
                ret_log.push_back(ReturnData);
                ret_n++;
            end
            if (PPPRefillDataValid && PPPRefillDataReady) begin
                if (refill_q.size() > 0) check("refill_leaf", PPPRefillData, refill_q.pop_front());
                else timeout_fail("refill_unexpected");
                refill_log.push_back(PPPRefillData);
            end
            if (mode_m == M_FAKE) check("fake_load_ready", LoadDataReady, 1'b0);
            if (mode_m == M_STORE && Busy) check("datain_ready_follow", DataInReady, StoreDataReady);
        end
    end

    task automatic clear_model();
        evict_q.delete(); refill_q.delete(); datain_q.delete(); loadret_q.delete();
        store_log.delete(); ret_log.delete(); refill_log.delete();
        store_n = 0; ret_n = 0;
    endtask

    task automatic switch_to(input logic dbr, input logic [1:0] cmd, input logic dummy, input int m);
        DataBlockReq = dbr; Cmd = cmd; DummyReq = dummy; SwitchReq = 1;
        mode_m = m; store_n = 0; ret_n = 0; store_log.delete(); ret_log.delete();
        @(posedge Clock); #1;
        SwitchReq = 0;
    endtask

    task automatic evict_leaf(input logic [LW-1:0] d);
        bit ok = 0;
        PPPEvictDataValid = 1; PPPEvictData = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (PPPEvictDataReady) begin ok = 1; break; end
        end
        @(posedge Clock); #1;
        PPPEvictDataValid = 0;
        if (!ok) timeout_fail("evict_handshake");
    endtask

    task automatic send_chunk(input logic [FW-1:0] d);
        bit ok = 0;
        DataInValid = 1; DataIn = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (DataInReady) begin ok = 1; break; end
        end
        @(posedge Clock); #1;
        DataInValid = 0;
        if (!ok) timeout_fail("datain_handshake");
    endtask

    task automatic load_chunk(input logic [FW-1:0] d);
        bit ok = 0;
        LoadDataValid = 1; LoadData = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            if (LoadDataReady) begin ok = 1; break; end
        end
        @(posedge Clock); #1;
        LoadDataValid = 0;
        if (!ok) timeout_fail("load_handshake");
    endtask

    task automatic wait_stores(input int n);
        for (int i = 0; i < 300; i++) begin
            if (store_n >= n) break;
            @(posedge Clock); #1;
        end
        if (store_n < n) timeout_fail("wait_stores");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!Busy) break;
            @(posedge Clock); #1;
        end
        if (Busy) timeout_fail("wait_idle");
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, Busy, 1'b0);
        check({tag, "_evict_ready"}, PPPEvictDataReady, 1'b1);
        check({tag, "_valids"}, {StoreDataValid, ReturnDataValid, PPPRefillDataValid}, 3'b000);
        check({tag, "_readies"}, {DataInReady, LoadDataReady}, 2'b00);
        check({tag, "_flags"}, {ErrUnexpectedLoad, ErrSwitchBusy}, 2'b00);
    endtask

    initial begin
        int acc;
        // Reset state
        repeat (2) @(negedge Clock);
        check_quiet("reset");
        check("reset_data", {StoreData, ReturnData ^ {PPPRefillData, 32'h0}}, 128'h0);
        @(posedge Clock); #1;
        Reset = 1;

        // POSMAP: 16 evicted leaves packed, 8 chunks refilled
        PPPRefillDataReady = 1; StoreDataReady = 1;
        switch_to(0, 2'd0, 0, M_POSMAP);
        check("posmap_busy", Busy, 1'b1);
        for (int i = 1; i <= 16; i++) evict_leaf(LW'(i));
        wait_stores(8);
        check("posmap_chunk0", store_log[0], 64'h00000002_00000001);
        check("posmap_chunk7", store_log[7], 64'h00000010_0000000F);
        for (int c = 0; c < 8; c++) begin
            if (c == 7) check("posmap_busy_before_last", Busy, 1'b1);
            load_chunk({32'hB000_0000 | 32'(2*c+1), 32'hB000_0000 | 32'(2*c)});
        end
        check("posmap_busy_falls", Busy, 1'b0);
        repeat (4) @(posedge Clock); #1;
        mode_m = M_IDLE;
        check("refill_count", refill_log.size(), 16);
        check("refill_leaf0", refill_log[0], 32'hB000_0000);
        check("refill_leaf1", refill_log[1], 32'hB000_0001);
        check("refill_leaf15", refill_log[15], 32'hB000_000F);

        // Reset mid-POSMAP with 5 leaves buffered
        clear_model();
        StoreDataReady = 0;
        switch_to(0, 2'd0, 0, M_POSMAP);
        for (int i = 0; i < 5; i++) evict_leaf(32'hC0 + LW'(i));
        Reset = 0;
        @(negedge Clock);
        check_quiet("midreset");
        @(posedge Clock); #1;
        Reset = 1; mode_m = M_IDLE;
        clear_model();

        // FAKE read with ReturnDataReady toggling
        StoreDataReady = 1; ReturnDataReady = 0;
        switch_to(1, 2'd2, 1, M_FAKE);
        check("fake_expecting", ExpectingProgramData, 1'b1);
        for (int i = 0; i < 100; i++) begin
            ReturnDataReady = ~ReturnDataReady;
            @(posedge Clock); #1;
            if (!Busy) break;
        end
        wait_idle();
        mode_m = M_IDLE;
        check("fake_stores", store_n, 8);
        check("fake_returns", ret_n, 8);
        check("fake_store7", store_log[7], 64'd7);
        check("fake_ret3", ret_log[3], 64'd3);

        // PROG_STORE with 4 stall cycles
        StoreDataReady = 0; DataInValid = 1; DataIn = 64'hD000_0000_0000_0000;
        switch_to(1, 2'd0, 0, M_STORE);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            check("store_stall_ready", DataInReady, 1'b0);
            @(posedge Clock); #1;
        end
        StoreDataReady = 1;
        for (int k = 0; k < 8; k++) send_chunk(64'hD000_0000_0000_0000 | FW'(k));
        wait_idle();
        mode_m = M_IDLE;
        check("store_count", store_n, 8);
        check("store_chunk0", store_log[0], 64'hD000_0000_0000_0000);
        check("store_chunk7", store_log[7], 64'hD000_0000_0000_0007);

        // Evict backpressure outside POSMAP: register stage plus 16-deep FIFO
        clear_model();
        acc = 0;
        PPPEvictDataValid = 1; PPPEvictData = 32'h100;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge Clock);
            check("evict_fill_ready", PPPEvictDataReady, acc < 17);
            if (PPPEvictDataReady) acc++;
            @(posedge Clock); #1;
            PPPEvictData = 32'h100 + LW'(acc);
        end
        PPPEvictDataValid = 0;
        check("evict_held", acc, 17);
        switch_to(0, 2'd0, 0, M_POSMAP);
        wait_stores(8);
        check("drain_chunk0", store_log[0], 64'h00000101_00000100);
        check("drain_chunk7", store_log[7], 64'h0000010F_0000010E);
        for (int c = 0; c < 8; c++) load_chunk(64'hE000_0000_0000_0000 | FW'(c));
        wait_idle();
        repeat (4) @(posedge Clock); #1;
        mode_m = M_IDLE;
        check("drain_left", evict_q.size(), 1);

        // PROG_LOAD with SwitchReq while busy and in the completion cycle
        ReturnDataReady = 1;
        check("err_switch_clear", ErrSwitchBusy, 1'b0);
        switch_to(1, 2'd3, 0, M_LOAD);
        SwitchReq = 1; DataBlockReq = 0;
        @(posedge Clock); #1;
        SwitchReq = 0; DataBlockReq = 1;
        check("err_switch_set", ErrSwitchBusy, 1'b1);
        check("switch_mode_kept", ExpectingProgramData, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin SwitchReq = 1; DataBlockReq = 0; end
            load_chunk(64'h1111_0000_0000_0000 | FW'(k));
        end
        SwitchReq = 0; DataBlockReq = 1;
        check("load_done_idle", Busy, 1'b0);
        @(posedge Clock); #1;
        check("completion_switch_rejected", Busy, 1'b0);
        mode_m = M_IDLE;
        check("load_returns", ret_n, 8);
        check("load_ret0", ret_log[0], 64'h1111_0000_0000_0000);
        check("load_ret7", ret_log[7], 64'h1111_0000_0000_0007);

        // LoadDataValid in IDLE
        check("err_load_clear", ErrUnexpectedLoad, 1'b0);
        LoadDataValid = 1;
        @(posedge Clock); #1;
        LoadDataValid = 0;
        check("err_load_set", ErrUnexpectedLoad, 1'b1);
        @(posedge Clock); #1;
        check("err_flags_sticky", {ErrUnexpectedLoad, ErrSwitchBusy}, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
